// File: rtl/main_memory_responder.sv
// Backing-store responder for the cache miss path: whole-block reads and
// write-backs completed after a fixed access latency.
module main_memory_responder #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 20,
  parameter int BLK_WORDS = 4,
  parameter int LATENCY   = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   mem_req,
  input  logic                                   mem_rw,
  input  logic [ADDR_W-$clog2(BLK_WORDS)-1:0]    mem_block_addr,
  input  logic [BLK_WORDS*DATA_W-1:0]            mem_wdata,
  output logic [BLK_WORDS*DATA_W-1:0]            mem_rdata,
  output logic                                   mem_ready,
  output logic                                   mem_busy
);

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int BA_W  = ADDR_W - OFF_W;
  localparam int BLK_W = BLK_WORDS * DATA_W;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit DIRECT = (LATENCY == 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [BLK_W-1:0]  wdata_q, wdata_d;
  logic [BLK_W-1:0]  rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic              acc_s;
  logic              acc_rw_s;
  logic [BA_W-1:0]   acc_addr_s;
  logic [BLK_W-1:0]  acc_wdata_s;
  logic              wr_en_s;

  // Words are kept XOR-ed with their own address, so an all-zero power-up
  // image reads back as mem[i] = i.
  logic [DATA_W-1:0] mem_array [DEPTH];

  function automatic logic [ADDR_W-1:0] word_addr(input logic [BA_W-1:0] blk, input int k);
    return (ADDR_W'(blk) << OFF_W) | ADDR_W'(k);
  endfunction

  function automatic logic [DATA_W-1:0] addr_key(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  // Next-state, capture and access decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ready_d     = 1'b0;
    busy_d      = 1'b0;
    acc_s       = 1'b0;
    acc_rw_s    = rw_q;
    acc_addr_s  = addr_q;
    acc_wdata_s = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          rw_d    = mem_rw;
          addr_d  = mem_block_addr;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LATENCY);
          busy_d  = 1'b1;
          if (DIRECT) begin
            acc_s       = 1'b1;
            acc_rw_s    = mem_rw;
            acc_addr_s  = mem_block_addr;
            acc_wdata_s = mem_wdata;
            ready_d     = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          acc_s   = 1'b1;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is only reloaded by a completing read.
  always_comb begin
    rdata_d = rdata_q;
    if (acc_s && !acc_rw_s) begin
      for (int k = 0; k < BLK_WORDS; k++) begin
        rdata_d[k*DATA_W +: DATA_W] = mem_array[word_addr(acc_addr_s, k)]
                                      ^ addr_key(word_addr(acc_addr_s, k));
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Gating with rst keeps a write from landing while reset is asserted.
  assign wr_en_s = acc_s && acc_rw_s && rst;

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array; reset leaves its contents untouched.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < BLK_WORDS; k++) begin
        mem_array[word_addr(acc_addr_s, k)] <= acc_wdata_s[k*DATA_W +: DATA_W]
                                               ^ addr_key(word_addr(acc_addr_s, k));
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: one responder with LATENCY = 4 and one with LATENCY = 1.
module tb_main_memory_responder;

  typedef struct {
    logic [79:0] rd;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req   [2];
  logic        rw    [2];
  logic [7:0]  baddr [2];
  logic [79:0] wdata [2];
  logic [79:0] rdata [2];
  logic        rdy   [2];
  logic        busy  [2];

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t mon_e;

  main_memory_responder #(.ADDR_W(10), .DATA_W(20), .BLK_WORDS(4), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst_n), .mem_req(req[0]), .mem_rw(rw[0]),
    .mem_block_addr(baddr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_ready(rdy[0]), .mem_busy(busy[0])
  );

  main_memory_responder #(.ADDR_W(10), .DATA_W(20), .BLK_WORDS(4), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_n), .mem_req(req[1]), .mem_rw(rw[1]),
    .mem_block_addr(baddr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_ready(rdy[1]), .mem_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse is matched against the next queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_ready_%0d", d), 80'd1, 80'd0);
        end else begin
          if (d == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("rdata_%0d", d), rdata[d], mon_e.rd);
          chk($sformatf("ready_cycle_%0d", d), 80'(cyc), 80'(mon_e.cyc));
          chk($sformatf("busy_in_done_%0d", d), 80'(busy[d]), 80'd1);
        end
      end
    end
  end

  // Issue one request at #1 after an edge; dly = cycles from drive to ready.
  task automatic run_req(input int d, input bit w, input logic [7:0] a,
                         input logic [79:0] wd, input logic [79:0] exp_rd,
                         input int dly, input bit mutate);
    exp_t e;
    bit   seen;
    int   acc_cyc;
    req[d]   = 1'b1;
    rw[d]    = w;
    baddr[d] = a;
    wdata[d] = wd;
    e.rd     = exp_rd;
    e.cyc    = cyc + dly;
    acc_cyc  = cyc + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (mutate) begin
      @(posedge clk);
      #1;
      rw[d]    = 1'b1;
      baddr[d] = baddr[d] + 8'd1;
      wdata[d] = {80{1'b1}};
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (cyc >= acc_cyc) chk($sformatf("busy_wait_%0d", d), 80'(busy[d]), 80'd1);
    end
    if (!seen) chk($sformatf("ready_timeout_%0d", d), 80'd0, 80'd1);
    @(posedge clk);
    #1;
    req[d] = 1'b0;
    rw[d]  = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_one_cycle_%0d", d), 80'(rdy[d]), 80'd0);
    chk($sformatf("busy_idle_%0d", d), 80'(busy[d]), 80'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; rw[d] = 1'b0; baddr[d] = 8'h00; wdata[d] = 80'h0;
    end
    req[0]   = 1'b1;
    baddr[0] = 8'h05;

    // Reset held with a request pending.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 80'(rdy[0]), 80'd0);
    chk("rst_busy", 80'(busy[0]), 80'd0);
    chk("rst_rdata", rdata[0], 80'h0);
    chk("rst_rdata_l1", rdata[1], 80'h0);
    rst_n = 1'b1;

    // LATENCY = 4: accept on the next edge, ready 4 edges later -> 5 cycles from drive.
    run_req(0, 1'b0, 8'h05, 80'h0, 80'h00017_00016_00015_00014, 5, 1'b0);
    run_req(0, 1'b1, 8'h3A, 80'hDDDDD_CCCCC_BBBBB_AAAAA, 80'h00017_00016_00015_00014, 5, 1'b0);
    run_req(0, 1'b0, 8'h3A, 80'h0, 80'hDDDDD_CCCCC_BBBBB_AAAAA, 5, 1'b0);
    run_req(0, 1'b0, 8'h01, 80'h0, 80'h00007_00006_00005_00004, 5, 1'b1);
    run_req(0, 1'b0, 8'h02, 80'h0, 80'h0000B_0000A_00009_00008, 5, 1'b0);

    // Reset two cycles into a write of block 0x10.
    req[0] = 1'b1; rw[0] = 1'b1; baddr[0] = 8'h10; wdata[0] = 80'h12345_6789A_BCDEF_01234;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    rw[0]  = 1'b0;
    #1;
    chk("midrst_ready", 80'(rdy[0]), 80'd0);
    chk("midrst_busy", 80'(busy[0]), 80'd0);
    chk("midrst_rdata", rdata[0], 80'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_req(0, 1'b0, 8'h10, 80'h0, 80'h00043_00042_00041_00040, 5, 1'b0);

    // LATENCY = 1: the accepting edge performs the access, ready 1 cycle from drive.
    run_req(1, 1'b0, 8'hFF, 80'h0, 80'h003FF_003FE_003FD_003FC, 1, 1'b0);
    run_req(1, 1'b1, 8'hFF, 80'h11111_22222_33333_44444, 80'h003FF_003FE_003FD_003FC, 1, 1'b0);
    run_req(1, 1'b0, 8'h00, 80'h0, 80'h00003_00002_00001_00000, 1, 1'b0);
    run_req(1, 1'b0, 8'hFF, 80'h0, 80'h11111_22222_33333_44444, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue0_drained", 80'(q0.size()), 80'd0);
    chk("queue1_drained", 80'(q1.size()), 80'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
